// File: rtl/snake_motion_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : snake_motion_ctrl
//  Description : Snake game-state stage. Advances the snake one cell per
//                game tick, latches button direction, detects food, wall
//                and self collisions, grows the body and serves a registered
//                segment read port to the renderer.
//  Revision    : 1.0 - initial release
// ============================================================================
module snake_motion_ctrl #(
    parameter int GRID_W  = 40,
    parameter int GRID_H  = 30,
    parameter int MAX_LEN = 32
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       game_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic [5:0] food_x,
    input  logic [4:0] food_y,
    input  logic       food_valid,
    input  logic [4:0] rd_idx,
    output logic [5:0] rd_x,
    output logic [4:0] rd_y,
    output logic       rd_valid,
    output logic [5:0] head_x,
    output logic [4:0] head_y,
    output logic [5:0] snake_len,
    output logic       eat_pulse,
    output logic       game_over,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CALC   = 3'd1,
        S_SCAN   = 3'd2,
        S_UPDATE = 3'd3,
        S_OVER   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    localparam logic [5:0] c_X_MAX    = 6'(GRID_W - 1);
    localparam logic [4:0] c_Y_MAX    = 5'(GRID_H - 1);
    localparam logic [5:0] c_START_X  = 6'(GRID_W / 2);
    localparam logic [4:0] c_START_Y  = 5'(GRID_H / 2);
    localparam logic [5:0] c_MAX_LEN  = 6'(MAX_LEN);
    localparam logic [4:0] c_LAST_IDX = 5'(MAX_LEN - 1);

    state_t                     state_q;
    dir_t                       dir_q;
    dir_t                       pend_q;
    dir_t                       pend_d;
    logic [MAX_LEN-1:0][5:0]    seg_x_q;
    logic [MAX_LEN-1:0][4:0]    seg_y_q;
    logic [5:0]                 len_q;
    logic [5:0]                 nx_q;
    logic [4:0]                 ny_q;
    logic                       wall_q;
    logic                       eat_q;
    logic                       hit_q;
    logic [4:0]                 idx_q;
    logic                       eat_pulse_q;
    logic                       over_q;

    logic [5:0]                 nx_d;
    logic [4:0]                 ny_d;
    logic                       wall_d;
    logic                       eat_d;
    logic [5:0]                 scan_limit_d;
    logic                       scan_match_d;

    assign head_x    = seg_x_q[0];
    assign head_y    = seg_y_q[0];
    assign snake_len = len_q;
    assign eat_pulse = eat_pulse_q;
    assign game_over = over_q;
    assign busy      = (state_q == S_CALC) || (state_q == S_SCAN) || (state_q == S_UPDATE);

    // Highest-priority pressed button becomes pending unless it reverses the committed direction
    always_comb begin
        pend_d = pend_q;
        if (btn_up) begin
            if (dir_q != DIR_DOWN) pend_d = DIR_UP;
        end else if (btn_down) begin
            if (dir_q != DIR_UP) pend_d = DIR_DOWN;
        end else if (btn_left) begin
            if (dir_q != DIR_RIGHT) pend_d = DIR_LEFT;
        end else if (btn_right) begin
            if (dir_q != DIR_LEFT) pend_d = DIR_RIGHT;
        end
    end

    // Candidate head one step from the current head; leaving the grid (including 0-1 wrap) is a wall hit
    always_comb begin
        nx_d   = seg_x_q[0];
        ny_d   = seg_y_q[0];
        wall_d = 1'b0;
        case (pend_q)
            DIR_UP: begin
                ny_d   = seg_y_q[0] - 5'd1;
                wall_d = (seg_y_q[0] == 5'd0);
            end
            DIR_DOWN: begin
                ny_d   = seg_y_q[0] + 5'd1;
                wall_d = (seg_y_q[0] >= c_Y_MAX);
            end
            DIR_LEFT: begin
                nx_d   = seg_x_q[0] - 6'd1;
                wall_d = (seg_x_q[0] == 6'd0);
            end
            default: begin
                nx_d   = seg_x_q[0] + 6'd1;
                wall_d = (seg_x_q[0] >= c_X_MAX);
            end
        endcase
        eat_d = food_valid && (nx_d == food_x) && (ny_d == food_y);
    end

    // Body collision test for the segment under scan; the tail is excluded unless the snake grows
    always_comb begin
        scan_limit_d = eat_q ? len_q : (len_q - 6'd1);
        scan_match_d = ({1'b0, idx_q} < scan_limit_d) &&
                       (seg_x_q[idx_q] == nx_q) && (seg_y_q[idx_q] == ny_q);
    end

    // Pending direction register, sampled every cycle
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            pend_q <= DIR_RIGHT;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Move sequencer: IDLE -> CALC -> SCAN x MAX_LEN -> UPDATE -> IDLE/OVER
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            dir_q       <= DIR_RIGHT;
            seg_x_q     <= '0;
            seg_y_q     <= '0;
            seg_x_q[0]  <= c_START_X;
            seg_x_q[1]  <= c_START_X - 6'd1;
            seg_x_q[2]  <= c_START_X - 6'd2;
            seg_y_q[0]  <= c_START_Y;
            seg_y_q[1]  <= c_START_Y;
            seg_y_q[2]  <= c_START_Y;
            len_q       <= 6'd3;
            nx_q        <= '0;
            ny_q        <= '0;
            wall_q      <= 1'b0;
            eat_q       <= 1'b0;
            hit_q       <= 1'b0;
            idx_q       <= '0;
            eat_pulse_q <= 1'b0;
            over_q      <= 1'b0;
        end else begin
            eat_pulse_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (game_tick) state_q <= S_CALC;
                end
                S_CALC: begin
                    dir_q   <= pend_q;
                    nx_q    <= nx_d;
                    ny_q    <= ny_d;
                    wall_q  <= wall_d;
                    eat_q   <= eat_d;
                    hit_q   <= 1'b0;
                    idx_q   <= '0;
                    state_q <= S_SCAN;
                end
                S_SCAN: begin
                    if (scan_match_d) hit_q <= 1'b1;
                    idx_q <= idx_q + 5'd1;
                    if (idx_q == c_LAST_IDX) state_q <= S_UPDATE;
                end
                S_UPDATE: begin
                    if (wall_q || hit_q) begin
                        over_q  <= 1'b1;
                        state_q <= S_OVER;
                    end else begin
                        seg_x_q <= {seg_x_q[MAX_LEN-2:0], nx_q};
                        seg_y_q <= {seg_y_q[MAX_LEN-2:0], ny_q};
                        if (eat_q) begin
                            if (len_q < c_MAX_LEN) len_q <= len_q + 6'd1;
                            eat_pulse_q <= 1'b1;
                        end
                        state_q <= S_IDLE;
                    end
                end
                S_OVER: begin
                    state_q <= S_OVER;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Renderer read port, one-cycle latency, active in every state
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            rd_x     <= '0;
            rd_y     <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_x     <= seg_x_q[rd_idx];
            rd_y     <= seg_y_q[rd_idx];
            rd_valid <= ({1'b0, rd_idx} < len_q);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_snake_motion_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_snake_motion_ctrl
//  Description : Directed, table-driven bench for snake_motion_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_snake_motion_ctrl;

    logic       clk_100MHz = 1'b0;
    logic       reset      = 1'b1;
    logic       game_tick  = 1'b0;
    logic       btn_up     = 1'b0;
    logic       btn_down   = 1'b0;
    logic       btn_left   = 1'b0;
    logic       btn_right  = 1'b0;
    logic [5:0] food_x     = '0;
    logic [4:0] food_y     = '0;
    logic       food_valid = 1'b0;
    logic [4:0] rd_idx     = '0;
    logic [5:0] rd_x;
    logic [4:0] rd_y;
    logic       rd_valid;
    logic [5:0] head_x;
    logic [4:0] head_y;
    logic [5:0] snake_len;
    logic       eat_pulse;
    logic       game_over;
    logic       busy;

    snake_motion_ctrl dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .game_tick  (game_tick),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .food_x     (food_x),
        .food_y     (food_y),
        .food_valid (food_valid),
        .rd_idx     (rd_idx),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_valid   (rd_valid),
        .head_x     (head_x),
        .head_y     (head_y),
        .snake_len  (snake_len),
        .eat_pulse  (eat_pulse),
        .game_over  (game_over),
        .busy       (busy)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    // One tick of stimulus and the state expected once the move completes
    typedef struct {
        bit         rst;
        logic [3:0] btn;    // {up, down, left, right}
        bit         fv;
        logic [5:0] fx;
        logic [4:0] fy;
        int         hx;
        int         hy;
        int         len;
        bit         eat;
        bit         over;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cur_hx, cur_hy, cur_len;
    bit cur_over;
    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input bit rst, input logic [3:0] btn, input bit fv,
                                input int fx, input int fy, input int hx, input int hy,
                                input int len, input bit eat, input bit over);
        vec_t v;
        v.rst = rst; v.btn = btn; v.fv = fv; v.fx = 6'(fx); v.fy = 5'(fy);
        v.hx = hx; v.hy = hy; v.len = len; v.eat = eat; v.over = over;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk_100MHz);
        reset = 1'b1;
        game_tick = 1'b0;
        {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
        food_valid = 1'b0;
        @(negedge clk_100MHz);
        reset = 1'b0;
        cur_hx = 20; cur_hy = 15; cur_len = 3; cur_over = 1'b0;
    endtask

    task automatic read_chk(input int idx, input int ex, input int ey, input bit ev);
        @(negedge clk_100MHz);
        rd_idx = 5'(idx);
        @(negedge clk_100MHz);
        chk($sformatf("rd_valid[%0d]", idx), rd_valid, ev);
        if (ev) begin
            chk($sformatf("rd_x[%0d]", idx), rd_x, ex);
            chk($sformatf("rd_y[%0d]", idx), rd_y, ey);
        end
    endtask

    // Tick once, confirm nothing is visible after 34 edges and everything at edge 35
    task automatic apply_vec(input vec_t v);
        if (v.rst) do_reset();
        @(negedge clk_100MHz);
        {btn_up, btn_down, btn_left, btn_right} = v.btn;
        food_valid = v.fv; food_x = v.fx; food_y = v.fy;
        game_tick = 1'b1;
        @(negedge clk_100MHz);
        game_tick = 1'b0;
        repeat (33) @(negedge clk_100MHz);
        chk("mid_busy", busy, !cur_over);
        chk("mid_head_x", head_x, cur_hx);
        chk("mid_eat", eat_pulse, 1'b0);
        @(negedge clk_100MHz);
        chk("head_x", head_x, v.hx);
        chk("head_y", head_y, v.hy);
        chk("snake_len", snake_len, v.len);
        chk("eat_pulse", eat_pulse, v.eat);
        chk("game_over", game_over, v.over);
        chk("busy_done", busy, 1'b0);
        @(negedge clk_100MHz);
        chk("eat_pulse_off", eat_pulse, 1'b0);
        {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
        food_valid = 1'b0;
        cur_hx = v.hx; cur_hy = v.hy; cur_len = v.len; cur_over = v.over;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        // Reset values while reset is held, then first read after release
        repeat (2) @(negedge clk_100MHz);
        chk("rst_head_x", head_x, 20);
        chk("rst_head_y", head_y, 15);
        chk("rst_len", snake_len, 3);
        chk("rst_eat", eat_pulse, 1'b0);
        chk("rst_over", game_over, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rd_x", rd_x, 0);
        chk("rst_rd_y", rd_y, 0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        reset = 1'b0;
        cur_hx = 20; cur_hy = 15; cur_len = 3; cur_over = 1'b0;
        read_chk(0, 20, 15, 1'b1);
        read_chk(2, 18, 15, 1'b1);
        read_chk(3, 0, 0, 1'b0);

        //               rst  btn      fv fx  fy  hx  hy len eat over
        tbl[0]  = mk(1, 4'b0000, 0, 21, 15, 21, 15, 3, 0, 0);   // plain move, food not valid
        tbl[1]  = mk(1, 4'b0010, 0,  0,  0, 21, 15, 3, 0, 0);   // left rejected as reversal
        tbl[2]  = mk(0, 4'b1000, 0,  0,  0, 21, 14, 3, 0, 0);   // up
        tbl[3]  = mk(1, 4'b0000, 1, 21, 15, 21, 15, 4, 1, 0);   // eat
        tbl[4]  = mk(0, 4'b0100, 1, 21, 16, 21, 16, 5, 1, 0);   // down + eat -> len 5
        tbl[5]  = mk(0, 4'b0010, 0,  0,  0, 20, 16, 5, 0, 0);   // left
        tbl[6]  = mk(0, 4'b1000, 0,  0,  0, 20, 16, 5, 0, 1);   // up into body
        tbl[7]  = mk(0, 4'b0000, 0,  0,  0, 20, 16, 5, 0, 1);   // ignored in OVER
        tbl[8]  = mk(1, 4'b0000, 1, 21, 15, 21, 15, 4, 1, 0);   // eat -> len 4
        tbl[9]  = mk(0, 4'b0100, 0,  0,  0, 21, 16, 4, 0, 0);
        tbl[10] = mk(0, 4'b0010, 0,  0,  0, 20, 16, 4, 0, 0);
        tbl[11] = mk(0, 4'b1000, 0,  0,  0, 20, 15, 4, 0, 0);   // into vacating tail
        tbl[12] = mk(0, 4'b0100, 0,  0,  0, 20, 14, 4, 0, 0);   // down rejected, keeps up

        for (int i = 0; i < 13; i++) begin
            apply_vec(tbl[i]);
            if (i == 0) begin
                read_chk(0, 21, 15, 1'b1);
                read_chk(1, 20, 15, 1'b1);
                read_chk(2, 19, 15, 1'b1);
            end
            if (i == 3) begin
                read_chk(3, 18, 15, 1'b1);
                read_chk(4, 0, 0, 1'b0);
            end
        end

        // Right wall
        for (int k = 0; k < 19; k++) apply_vec(mk(k == 0, 4'b0000, 0, 0, 0, 21 + k, 15, 3, 0, 0));
        apply_vec(mk(0, 4'b0000, 0, 0, 0, 39, 15, 3, 0, 1));
        apply_vec(mk(0, 4'b1000, 0, 0, 0, 39, 15, 3, 0, 1));

        // Top wall
        for (int k = 0; k < 15; k++) apply_vec(mk(k == 0, 4'b1000, 0, 0, 0, 20, 14 - k, 3, 0, 0));
        apply_vec(mk(0, 4'b1000, 0, 0, 0, 20, 0, 3, 0, 1));

        // Bottom wall
        for (int k = 0; k < 14; k++) apply_vec(mk(k == 0, 4'b0100, 0, 0, 0, 20, 16 + k, 3, 0, 0));
        apply_vec(mk(0, 4'b0100, 0, 0, 0, 20, 29, 3, 0, 1));

        // Left wall
        apply_vec(mk(1, 4'b1000, 0, 0, 0, 20, 14, 3, 0, 0));
        for (int k = 0; k < 20; k++) apply_vec(mk(0, 4'b0010, 0, 0, 0, 19 - k, 14, 3, 0, 0));
        apply_vec(mk(0, 4'b0010, 0, 0, 0, 0, 14, 3, 0, 1));

        // Tick while busy is dropped
        do_reset();
        @(negedge clk_100MHz); game_tick = 1'b1;
        @(negedge clk_100MHz); game_tick = 1'b0;
        repeat (9) @(negedge clk_100MHz);
        chk("drop_busy", busy, 1'b1);
        game_tick = 1'b1;
        @(negedge clk_100MHz); game_tick = 1'b0;
        repeat (24) @(negedge clk_100MHz);
        chk("drop_head_x", head_x, 21);
        repeat (40) @(negedge clk_100MHz);
        chk("drop_head_x_later", head_x, 21);
        chk("drop_busy_later", busy, 1'b0);

        // Asynchronous reset in the middle of SCAN
        do_reset();
        rd_idx = 5'd0;
        @(negedge clk_100MHz); game_tick = 1'b1;
        @(negedge clk_100MHz); game_tick = 1'b0;
        repeat (10) @(negedge clk_100MHz);
        chk("pre_rst_busy", busy, 1'b1);
        chk("pre_rst_rd_valid", rd_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("async_busy", busy, 1'b0);
        chk("async_head_x", head_x, 20);
        chk("async_len", snake_len, 3);
        chk("async_rd_valid", rd_valid, 1'b0);
        chk("async_rd_x", rd_x, 0);
        chk("async_over", game_over, 1'b0);
        @(negedge clk_100MHz); reset = 1'b0;
        repeat (40) @(negedge clk_100MHz);
        chk("post_rst_head_x", head_x, 20);
        chk("post_rst_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
